// File: rtl/aud_sram_arbiter_if.sv
// Request/response and SRAM pin bundle for the audio SRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' and SRAM side.
interface aud_sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_rd_past_end;
    logic              i_clr_len;
    logic [ADDR_W:0]   o_rec_len;
    logic              o_busy;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_wdata;
    logic              o_sram_wdata_en;
    logic [DATA_W-1:0] i_sram_rdata;
    logic              o_sram_ce_n;
    logic              o_sram_we_n;
    logic              o_sram_oe_n;
    logic              o_sram_lb_n;
    logic              o_sram_ub_n;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_clr_len, i_sram_rdata,
        output o_wr_ack, o_rd_data, o_rd_valid, o_rd_past_end, o_rec_len, o_busy,
               o_sram_addr, o_sram_wdata, o_sram_wdata_en,
               o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_clr_len, i_sram_rdata,
        input  o_wr_ack, o_rd_data, o_rd_valid, o_rd_past_end, o_rec_len, o_busy,
               o_sram_addr, o_sram_wdata, o_sram_wdata_en,
               o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
    );
endinterface

// File: rtl/aud_sram_arbiter.sv
// Single-port SRAM scheduler: round-robin between recorder writes and DSP reads,
// fixed-length accesses followed by a one-cycle turnaround gap, and recorded-length tracking.
module aud_sram_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    aud_sram_arbiter_if.slave  bus
);
    localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_GAP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              past_end_q;
    logic              wr_ack_q;
    logic              rd_valid_q;
    logic [ADDR_W:0]   rec_len_q;
    logic              ce_n_q;
    logic              we_n_q;
    logic              oe_n_q;
    logic              wdata_en_q;

    logic grant_wr_d;
    logic last_cyc_d;
    logic past_end_d;

    // Recorded length only grows; the ADDR_W+1 width holds 2^ADDR_W without wrapping.
    function automatic logic [ADDR_W:0] len_after_write(input logic [ADDR_W:0]   cur,
                                                        input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] end_p1;
        end_p1 = {1'b0, addr} + (ADDR_W+1)'(1);
        return (end_p1 > cur) ? end_p1 : cur;
    endfunction

    // On a tie, grant whichever side did not win last time.
    assign grant_wr_d = bus.i_wr_req && (!bus.i_rd_req || !last_wr_q);
    assign last_cyc_d = (cnt_q == CNT_W'(ACC_CYC - 1));
    assign past_end_d = ({1'b0, addr_q} >= rec_len_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            past_end_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rec_len_q  <= '0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            wdata_en_q <= 1'b0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_wr_req || bus.i_rd_req) begin
                        addr_q     <= grant_wr_d ? bus.i_wr_addr : bus.i_rd_addr;
                        if (grant_wr_d) wdata_q <= bus.i_wr_data;
                        last_wr_q  <= grant_wr_d;
                        cnt_q      <= '0;
                        ce_n_q     <= 1'b0;
                        we_n_q     <= !grant_wr_d;
                        oe_n_q     <= grant_wr_d;
                        wdata_en_q <= grant_wr_d;
                        state_q    <= grant_wr_d ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (last_cyc_d) begin
                        state_q    <= S_GAP;
                        ce_n_q     <= 1'b1;
                        we_n_q     <= 1'b1;
                        wdata_en_q <= 1'b0;
                        wr_ack_q   <= 1'b1;
                        rec_len_q  <= len_after_write(rec_len_q, addr_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (last_cyc_d) begin
                        state_q    <= S_GAP;
                        ce_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                        past_end_q <= past_end_d;
                        rd_data_q  <= past_end_d ? '0 : bus.i_sram_rdata;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // A clear on the write-ending edge overrides that write's length update.
            if (bus.i_clr_len) rec_len_q <= '0;
        end
    end

    assign bus.o_wr_ack        = wr_ack_q;
    assign bus.o_rd_valid      = rd_valid_q;
    assign bus.o_rd_data       = rd_data_q;
    assign bus.o_rd_past_end   = past_end_q;
    assign bus.o_rec_len       = rec_len_q;
    assign bus.o_busy          = (state_q != S_IDLE);
    assign bus.o_sram_addr     = addr_q;
    assign bus.o_sram_wdata    = wdata_q;
    assign bus.o_sram_wdata_en = wdata_en_q;
    assign bus.o_sram_ce_n     = ce_n_q;
    assign bus.o_sram_we_n     = we_n_q;
    assign bus.o_sram_oe_n     = oe_n_q;
    assign bus.o_sram_lb_n     = 1'b0;
    assign bus.o_sram_ub_n     = 1'b0;
endmodule

// File: tb/tb_aud_sram_arbiter.sv
// Directed bench for aud_sram_arbiter with a small behavioural SRAM (256 words, low address bits).
module tb_aud_sram_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [15:0] mem [256];

    aud_sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    aud_sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.o_sram_ce_n && !bus.o_sram_we_n) mem[bus.o_sram_addr[7:0]] <= bus.o_sram_wdata;
    end
    assign bus.i_sram_rdata = (!bus.o_sram_ce_n && !bus.o_sram_oe_n) ? mem[bus.o_sram_addr[7:0]] : 16'h0000;

    // Raises one request, follows it to its ack/valid (bounded), then lets the FSM return to idle.
    task automatic run_req(input bit is_wr, input logic [19:0] a, input logic [15:0] d,
                           input int clr_edge, output int strb, output int done_at,
                           output logic [15:0] rdat, output logic pe, output int bad);
        strb = 0; done_at = -1; rdat = '0; pe = 1'b0; bad = 0;
        if (is_wr) begin
            bus.i_wr_addr = a; bus.i_wr_data = d; bus.i_wr_req = 1'b1;
        end else begin
            bus.i_rd_addr = a; bus.i_rd_req = 1'b1;
        end
        for (int i = 1; i <= 12 && done_at < 0; i++) begin
            bus.i_clr_len = (i == clr_edge);
            @(posedge clk); #1;
            bus.i_clr_len = 1'b0;
            if (!bus.o_sram_ce_n && (is_wr ? !bus.o_sram_we_n : !bus.o_sram_oe_n)) begin
                strb++;
                if (bus.o_sram_addr !== a || bus.o_sram_wdata_en !== is_wr) bad++;
                if (is_wr && bus.o_sram_wdata !== d) bad++;
            end
            if (is_wr ? bus.o_wr_ack : bus.o_rd_valid) begin
                done_at = i;
                rdat = bus.o_rd_data;
                pe = bus.o_rd_past_end;
                bus.i_wr_req = 1'b0;
                bus.i_rd_req = 1'b0;
            end
        end
        bus.i_wr_req = 1'b0;
        bus.i_rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_sram_ce_n, bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_wdata_en} !== 4'b1110) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 1110",
                {bus.o_sram_ce_n, bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_wdata_en});
        end
        n_checks++;
        if ({bus.o_wr_ack, bus.o_rd_valid, bus.o_rd_past_end, bus.o_busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                {bus.o_wr_ack, bus.o_rd_valid, bus.o_rd_past_end, bus.o_busy});
        end
        n_checks++;
        if (bus.o_rec_len !== 21'h0 || bus.o_rd_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_len_data: got len %h data %h expected 0 0", bus.o_rec_len, bus.o_rd_data);
        end
        n_checks++;
        if (bus.o_sram_addr !== 20'h0 || bus.o_sram_wdata !== 16'h0) begin
            n_fail++; $display("FAIL reset_addr_wdata: got %h %h expected 0 0", bus.o_sram_addr, bus.o_sram_wdata);
        end
        n_checks++;
        if (bus.o_sram_lb_n !== 1'b0 || bus.o_sram_ub_n !== 1'b0) begin
            n_fail++; $display("FAIL byte_lanes: got %b%b expected 00", bus.o_sram_lb_n, bus.o_sram_ub_n);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write;
        int strb, done_at, bad; logic [15:0] rdat; logic pe;
        run_req(1'b1, 20'h00010, 16'hBEEF, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (strb !== 2) begin n_fail++; $display("FAIL wr_strobe_len: got %0d expected 2", strb); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL wr_addr_data: got %0d bad cycles expected 0", bad); end
        n_checks++;
        if (done_at !== 3) begin n_fail++; $display("FAIL wr_ack_latency: got %0d expected 3", done_at); end
        n_checks++;
        if (bus.o_rec_len !== 21'h11) begin n_fail++; $display("FAIL wr_rec_len: got %h expected 11", bus.o_rec_len); end
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_sram_ce_n !== 1'b1) begin
            n_fail++; $display("FAIL wr_idle_after: got busy %b ce_n %b expected 0 1", bus.o_busy, bus.o_sram_ce_n);
        end
        n_checks++;
        if (bus.o_sram_addr !== 20'h00010) begin
            n_fail++; $display("FAIL addr_hold: got %h expected 00010", bus.o_sram_addr);
        end
    endtask

    task automatic test_read_back;
        int strb, done_at, bad; logic [15:0] rdat; logic pe;
        run_req(1'b0, 20'h00010, 16'h0, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (strb !== 2 || bad !== 0) begin n_fail++; $display("FAIL rd_strobe: got %0d cycles %0d bad expected 2 0", strb, bad); end
        n_checks++;
        if (done_at !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", done_at); end
        n_checks++;
        if (rdat !== 16'hBEEF || pe !== 1'b0) begin
            n_fail++; $display("FAIL rd_data: got %h pe %b expected BEEF 0", rdat, pe);
        end
        n_checks++;
        if (bus.o_rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data_hold: got %h expected BEEF", bus.o_rd_data); end
    endtask

    task automatic test_round_robin;
        byte kind [4];
        int  at [4];
        int  nev, viol;
        logic prev_we, prev_oe;
        nev = 0; viol = 0; prev_we = 1'b1; prev_oe = 1'b1;
        rst = 1'b1;
        bus.i_wr_addr = 20'h00040; bus.i_wr_data = 16'h1111; bus.i_rd_addr = 20'h00010;
        bus.i_wr_req = 1'b1; bus.i_rd_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (bus.o_rd_valid && nev < 4) begin kind[nev] = "R"; at[nev] = i; nev++; end
            if (bus.o_wr_ack && nev < 4) begin kind[nev] = "W"; at[nev] = i; nev++; end
            if ((!prev_we && !bus.o_sram_oe_n) || (!prev_oe && !bus.o_sram_we_n)) viol++;
            prev_we = bus.o_sram_we_n; prev_oe = bus.o_sram_oe_n;
            if (i == 15) begin bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0; end
        end
        @(posedge clk); #1;
        n_checks++;
        if (nev !== 4) begin n_fail++; $display("FAIL rr_events: got %0d expected 4", nev); end
        else begin
            n_checks++;
            if (kind[0] !== "R" || kind[1] !== "W" || kind[2] !== "R" || kind[3] !== "W") begin
                n_fail++; $display("FAIL rr_order: got %c%c%c%c expected RWRW", kind[0], kind[1], kind[2], kind[3]);
            end
            n_checks++;
            if (at[0] !== 3 || at[1] !== 7 || at[2] !== 11 || at[3] !== 15) begin
                n_fail++; $display("FAIL rr_spacing: got %0d %0d %0d %0d expected 3 7 11 15", at[0], at[1], at[2], at[3]);
            end
        end
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL rr_gap: got %0d back-to-back expected 0", viol); end
    endtask

    task automatic test_rec_len;
        int strb, done_at, bad; logic [15:0] rdat; logic pe;
        run_req(1'b1, 20'hFFFFF, 16'h1234, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (bus.o_rec_len !== 21'h100000) begin n_fail++; $display("FAIL len_max: got %h expected 100000", bus.o_rec_len); end
        run_req(1'b1, 20'h00020, 16'h2222, 3, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (done_at !== 3 || bus.o_rec_len !== 21'h0) begin
            n_fail++; $display("FAIL len_clear_wins: got ack %0d len %h expected 3 0", done_at, bus.o_rec_len);
        end
        run_req(1'b1, 20'h00004, 16'hAAAA, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (bus.o_rec_len !== 21'h5) begin n_fail++; $display("FAIL len_regrow: got %h expected 5", bus.o_rec_len); end
    endtask

    task automatic test_past_end;
        int strb, done_at, bad; logic [15:0] rdat; logic pe;
        run_req(1'b0, 20'h00005, 16'h0, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (rdat !== 16'h0000 || pe !== 1'b1 || done_at !== 3) begin
            n_fail++; $display("FAIL past_end: got data %h pe %b at %0d expected 0000 1 3", rdat, pe, done_at);
        end
        n_checks++;
        if (strb !== 2) begin n_fail++; $display("FAIL past_end_strobe: got %0d expected 2", strb); end
        run_req(1'b0, 20'h00004, 16'h0, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (rdat !== 16'hAAAA || pe !== 1'b0) begin
            n_fail++; $display("FAIL last_in_range: got %h pe %b expected AAAA 0", rdat, pe);
        end
    endtask

    task automatic test_reset_mid_write;
        int strb, done_at, bad, acks; logic [15:0] rdat; logic pe;
        acks = 0;
        bus.i_wr_addr = 20'h00030; bus.i_wr_data = 16'hC0DE; bus.i_wr_req = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start: got we_n %b expected 0", bus.o_sram_we_n); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.o_sram_ce_n, bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_wdata_en} !== 4'b1110) begin
            n_fail++; $display("FAIL rst_mid_strobes: got %b expected 1110",
                {bus.o_sram_ce_n, bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_wdata_en});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.o_wr_ack) acks++;
        end
        rst = 1'b0;
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_noack: got %0d acks expected 0", acks); end
        run_req(1'b1, 20'h00030, 16'hC0DE, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (done_at !== 3 || strb !== 2 || bus.o_rec_len !== 21'h31) begin
            n_fail++; $display("FAIL rst_mid_regrant: got ack %0d strobes %0d len %h expected 3 2 31",
                done_at, strb, bus.o_rec_len);
        end
        run_req(1'b0, 20'h00030, 16'h0, 0, strb, done_at, rdat, pe, bad);
        n_checks++;
        if (rdat !== 16'hC0DE || pe !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_readback: got %h pe %b expected C0DE 0", rdat, pe);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[5] = 16'h5555;
        rst = 1'b1;
        bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_rd_req = 1'b0; bus.i_rd_addr = '0; bus.i_clr_len = 1'b0;
        test_reset();
        test_single_write();
        test_read_back();
        test_round_robin();
        test_rec_len();
        test_past_end();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
